// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, word-addressed instruction memory, IF/ID register.
// Optional HALT detection is compiled in when IF_HALT_DETECT_EN is defined.
module instruction_fetch #(
    parameter int NB_ADDR   = 32,
    parameter int NB_INST   = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [NB_ADDR-1:0] i_branch_target,
    input  logic               i_mem_write,
    input  logic [NB_ADDR-1:0] i_mem_addr,
    input  logic [NB_INST-1:0] i_mem_data,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_INST-1:0] o_instruction,
    output logic               o_valid,
    output logic               o_halted
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef IF_HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    logic [NB_INST-1:0] mem_q [MEM_DEPTH];

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic [NB_ADDR-1:0] out_pc_q, out_pc_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic               valid_q, valid_d;
    logic [NB_INST-1:0] fetch_word;
    logic               is_halted;
    logic               unused_bits;

    // Address bits outside the word index are intentionally ignored (memory wraps).
    assign unused_bits = ^{i_mem_addr[NB_ADDR-1:AW+2], i_mem_addr[1:0], i_branch_target[1:0]};

    // Write port is independent of reset and enable; reads see the pre-edge contents.
    always_ff @(posedge i_clk) begin
        if (i_mem_write) begin
            mem_q[i_mem_addr[AW+1:2]] <= i_mem_data;
        end
    end

    assign fetch_word = mem_q[pc_q[AW+1:2]];

`ifdef IF_HALT_DETECT_EN
    assign is_halted = (state_q == HALTED);
`else
    assign is_halted = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        if (i_enable && !is_halted) begin
            state_d = RUN;
            if (i_branch_taken) begin
                pc_d    = {i_branch_target[NB_ADDR-1:2], 2'b00};
                inst_d  = '0;
                valid_d = 1'b0;
            end else if (!i_stall) begin
                inst_d   = fetch_word;
                out_pc_d = pc_q + NB_ADDR'(4);
                pc_d     = pc_q + NB_ADDR'(4);
                valid_d  = 1'b1;
`ifdef IF_HALT_DETECT_EN
                if (fetch_word == {NB_INST{1'b1}}) begin
                    state_d = HALTED;
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            out_pc_q <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

    assign o_pc          = out_pc_q;
    assign o_instruction = inst_q;
    assign o_valid       = valid_q;
    assign o_halted      = is_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch; HALT expectations follow IF_HALT_DETECT_EN.
module tb_instruction_fetch;

`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en, st, br, we;
    logic [31:0] tgt, wa, wd;
    logic [31:0] o_pc, o_inst;
    logic        o_valid, o_halted;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_stall        (st),
        .i_branch_taken (br),
        .i_branch_target(tgt),
        .i_mem_write    (we),
        .i_mem_addr     (wa),
        .i_mem_data     (wd),
        .o_pc           (o_pc),
        .o_instruction  (o_inst),
        .o_valid        (o_valid),
        .o_halted       (o_halted)
    );

    typedef struct {
        logic        en, st, br;
        logic [31:0] tgt;
        logic        we;
        logic [31:0] wa, wd;
        logic [31:0] epc, einst;
        logic        ev, eh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic s, logic b, logic [31:0] t, logic w,
                                logic [31:0] a, logic [31:0] d, logic [31:0] p,
                                logic [31:0] i, logic v, logic h);
        vec_t r;
        r.en = e; r.st = s; r.br = b; r.tgt = t; r.we = w; r.wa = a; r.wd = d;
        r.epc = p; r.einst = i; r.ev = v; r.eh = h;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] p, logic [31:0] i, logic v, logic h);
        total++;
        if (o_pc === p && o_inst === i && o_valid === v && o_halted === h) begin
            passed++;
            $display("ok   %s: pc=%h inst=%h valid=%0b halted=%0b", name, o_pc, o_inst, o_valid, o_halted);
        end else begin
            $display("FAIL %s: got pc=%h inst=%h valid=%0b halted=%0b, expected pc=%h inst=%h valid=%0b halted=%0b",
                     name, o_pc, o_inst, o_valid, o_halted, p, i, v, h);
        end
    endtask

    task automatic drive(vec_t r);
        @(negedge clk);
        en = r.en; st = r.st; br = r.br; tgt = r.tgt; we = r.we; wa = r.wa; wd = r.wd;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        en = 1'b0; st = 1'b0; br = 1'b0; we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; st = 1'b0; br = 1'b0; we = 1'b0;
        tgt = '0; wa = '0; wd = '0;

        mem_wr(32'd0, 32'h0041_1820);
        mem_wr(32'd4, 32'h0080_2820);
        mem_wr(32'd8, 32'h0000_0000);
        mem_wr(32'd12, 32'h0000_0000);
        for (int k = 4; k < 16; k++) mem_wr(32'(k * 4), 32'hA000_0000 + 32'(k));
        mem_wr(32'h0000_03FC, 32'h5555_AAAA);

        check("reset_state", 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //            en st br tgt            we wa    wd             exp_pc        exp_inst       v  h
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h0,        32'h0,         0, 0)); // idle hold
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h4,        32'h0041_1820, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0, 32'h0,         32'h4,        32'h0041_1820, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0, 32'h0,         32'h4,        32'h0041_1820, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0, 32'h0,         32'h4,        32'h0041_1820, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h8,        32'h0080_2820, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'hC,        32'h0,         1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h13,       0, 32'h0, 32'h0,         32'hC,        32'h0,         0, 0)); // redirect beats stall
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h14,       32'hA000_0004, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0, 32'h0,         32'h14,       32'hA000_0004, 1, 0)); // enable low
        vecs.push_back(mk(1, 0, 1, 32'h4,        0, 32'h0, 32'h0,         32'h14,       32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h4, 32'hABCD_0001, 32'h8,        32'h0080_2820, 1, 0)); // old data
        vecs.push_back(mk(1, 0, 1, 32'h4,        0, 32'h0, 32'h0,         32'h8,        32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h8,        32'hABCD_0001, 1, 0)); // new data
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC,0, 32'h0, 32'h0,         32'h8,        32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h0,        32'h5555_AAAA, 1, 0)); // pc wrap
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h0,         32'h4,        32'h0041_1820, 1, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n]);
            check($sformatf("vec%0d", n), vecs[n].epc, vecs[n].einst, vecs[n].ev, vecs[n].eh);
        end

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'd0, 32'd0, 1'b0, 1'b0);
        mem_wr(32'd8, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("restart_f0", 32'h4, 32'h0041_1820, 1'b1, 1'b0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("restart_f1", 32'h8, 32'hABCD_0001, 1'b1, 1'b0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("halt_word", 32'hC, 32'hFFFF_FFFF, 1'b1, HALT_EN);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (HALT_EN) check("halt_hold", 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b1);
        else         check("no_halt_next", 32'h10, 32'h0, 1'b1, 1'b0);
        drive(mk(1, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0));
        if (HALT_EN) check("halt_ignores_br", 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b1);
        else         check("no_halt_br", 32'h10, 32'h0, 1'b0, 1'b0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (HALT_EN) check("halt_hold2", 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b1);
        else         check("no_halt_refetch", 32'h4, 32'h0041_1820, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
